// File: rtl/fpu_input_interface_pkg.sv
// Shared mode/width/class macros (former header.h contents) and a package of
// derived constants used by the FPU input unpacker and its classifier.
`ifndef FPU_INPUT_INTERFACE_HEADER
`define FPU_INPUT_INTERFACE_HEADER
`define S_MODE 1'b0
`define D_MODE 1'b1
`define REG_SIZE 64
`define INPUT_INTERFACE_INT_OUT 53
`define INPUT_INTERFACE_EXP_OUT 11
`define CLS_ZERO 0
`define CLS_SUBNORMAL 1
`define CLS_NORMAL 2
`define CLS_INF 3
`define CLS_NAN 4
`endif

package fpu_input_interface_pkg;
  localparam int CLS_W      = 5;
  localparam int SGL_EXP_W  = 8;
  localparam int SGL_FRAC_W = 23;
  localparam int DBL_EXP_W  = 11;
  localparam int DBL_FRAC_W = 52;

  localparam logic [CLS_W-1:0] CLS_ZERO_OH = CLS_W'(1) << `CLS_ZERO;

  function automatic logic [CLS_W-1:0] cls_onehot(input int idx);
    return CLS_W'(1) << idx;
  endfunction
endpackage

// File: rtl/fpu_input_interface_fp_classify.sv
// Combinational IEEE-754 operand classifier: one-hot class and hidden bit
// from an unpacked (zero-extended) exponent and fraction.
module fp_classify
  import fpu_input_interface_pkg::*;
#(
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 52
) (
  input  logic              mode,
  input  logic [EXP_W-1:0]  exp,
  input  logic [FRAC_W-1:0] frac,
  output logic [CLS_W-1:0]  cls,
  output logic              hidden
);
  logic exp_zero;
  logic exp_ones;
  logic frac_zero;

  always_comb begin
    exp_zero  = (exp == '0);
    frac_zero = (frac == '0);
    // Single exponents arrive zero-extended, so only the low 8 bits can be all-ones.
    if (mode == `D_MODE) exp_ones = (exp[DBL_EXP_W-1:0] == '1);
    else                 exp_ones = (exp[SGL_EXP_W-1:0] == '1);
    hidden = !exp_zero;
    cls    = cls_onehot(`CLS_NORMAL);
    if (exp_zero && frac_zero)       cls = cls_onehot(`CLS_ZERO);
    else if (exp_zero)               cls = cls_onehot(`CLS_SUBNORMAL);
    else if (exp_ones && frac_zero)  cls = cls_onehot(`CLS_INF);
    else if (exp_ones)               cls = cls_onehot(`CLS_NAN);
  end
endmodule

// File: rtl/fpu_input_interface.sv
// Two-stage valid/ready unpacker for single/double IEEE-754 register operands.
// Optional build macro FPU_INPUT_INTERFACE_FTZ_EN flushes subnormals to signed zero.
module fpu_input_interface
  import fpu_input_interface_pkg::*;
#(
  parameter int INT_W = `INPUT_INTERFACE_INT_OUT,
  parameter int EXP_W = `INPUT_INTERFACE_EXP_OUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [`REG_SIZE-1:0] regA,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 modeA,
  output logic                 signA,
  output logic [EXP_W-1:0]     expA,
  output logic [INT_W-1:0]     intA,
  output logic [CLS_W-1:0]     classA
);
  localparam int FRAC_W = INT_W - 1;

  logic              vld_p1_q, vld_p1_d, mode_p1_q, mode_p1_d, sign_p1_q, sign_p1_d;
  logic [EXP_W-1:0]  exp_p1_q, exp_p1_d;
  logic [FRAC_W-1:0] frac_p1_q, frac_p1_d;

  logic              vld_p2_q, vld_p2_d, mode_p2_q, mode_p2_d, sign_p2_q, sign_p2_d;
  logic [EXP_W-1:0]  exp_p2_q, exp_p2_d;
  logic [INT_W-1:0]  int_p2_q, int_p2_d;
  logic [CLS_W-1:0]  cls_p2_q, cls_p2_d;

  logic              adv_p1, adv_p2, is_dbl, hidden_c;
  logic [CLS_W-1:0]  cls_c;

  // Stage 1: field extraction
  always_comb begin
    adv_p2    = !vld_p2_q || out_ready;
    adv_p1    = !vld_p1_q || adv_p2;
    is_dbl    = (mode == `D_MODE);
    vld_p1_d  = vld_p1_q;
    mode_p1_d = mode_p1_q;
    sign_p1_d = sign_p1_q;
    exp_p1_d  = exp_p1_q;
    frac_p1_d = frac_p1_q;
    if (adv_p1) vld_p1_d = in_valid;
    if (adv_p1 && in_valid) begin
      mode_p1_d = is_dbl ? `D_MODE : `S_MODE;
      sign_p1_d = is_dbl ? regA[63] : regA[31];
      exp_p1_d  = is_dbl ? EXP_W'(regA[62:52]) : EXP_W'(regA[30:23]);
      frac_p1_d = is_dbl ? FRAC_W'(regA[51:0]) : FRAC_W'(regA[22:0]);
    end
  end

  fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_classify (
    .mode   (mode_p1_q),
    .exp    (exp_p1_q),
    .frac   (frac_p1_q),
    .cls    (cls_c),
    .hidden (hidden_c)
  );

  // Stage 2: significand assembly and classification
  always_comb begin
    vld_p2_d  = vld_p2_q;
    mode_p2_d = mode_p2_q;
    sign_p2_d = sign_p2_q;
    exp_p2_d  = exp_p2_q;
    int_p2_d  = int_p2_q;
    cls_p2_d  = cls_p2_q;
    if (adv_p2) vld_p2_d = vld_p1_q;
    if (adv_p2 && vld_p1_q) begin
      mode_p2_d = mode_p1_q;
      sign_p2_d = sign_p1_q;
      exp_p2_d  = exp_p1_q;
      cls_p2_d  = cls_c;
      // Hidden bit sits just above the format's fraction so single stays right-aligned.
      int_p2_d  = INT_W'(frac_p1_q);
      if (mode_p1_q == `D_MODE) int_p2_d[DBL_FRAC_W] = hidden_c;
      else                      int_p2_d[SGL_FRAC_W] = hidden_c;
`ifdef FPU_INPUT_INTERFACE_FTZ_EN
      if (cls_c[`CLS_SUBNORMAL]) begin
        int_p2_d = '0;
        exp_p2_d = '0;
        cls_p2_d = CLS_ZERO_OH;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      mode_p1_q <= 1'b0;
      sign_p1_q <= 1'b0;
      exp_p1_q  <= '0;
      frac_p1_q <= '0;
      vld_p2_q  <= 1'b0;
      mode_p2_q <= 1'b0;
      sign_p2_q <= 1'b0;
      exp_p2_q  <= '0;
      int_p2_q  <= '0;
      cls_p2_q  <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      mode_p1_q <= mode_p1_d;
      sign_p1_q <= sign_p1_d;
      exp_p1_q  <= exp_p1_d;
      frac_p1_q <= frac_p1_d;
      vld_p2_q  <= vld_p2_d;
      mode_p2_q <= mode_p2_d;
      sign_p2_q <= sign_p2_d;
      exp_p2_q  <= exp_p2_d;
      int_p2_q  <= int_p2_d;
      cls_p2_q  <= cls_p2_d;
    end
  end

  assign in_ready  = adv_p1;
  assign out_valid = vld_p2_q;
  assign modeA     = mode_p2_q;
  assign signA     = sign_p2_q;
  assign expA      = exp_p2_q;
  assign intA      = int_p2_q;
  assign classA    = cls_p2_q;
endmodule

// File: tb/tb_fpu_input_interface.sv
// Directed self-checking bench for fpu_input_interface: reset, unpacking,
// specials, subnormals, throughput, backpressure and mid-flight reset.
module tb_fpu_input_interface;
  localparam logic MS = 1'b0;
  localparam logic MD = 1'b1;
  localparam logic [4:0] C_ZERO = 5'b00001;
  localparam logic [4:0] C_SUB  = 5'b00010;
  localparam logic [4:0] C_NORM = 5'b00100;
  localparam logic [4:0] C_INF  = 5'b01000;
  localparam logic [4:0] C_NAN  = 5'b10000;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, mode, out_valid, out_ready, modeA, signA;
  logic [63:0] regA;
  logic [10:0] expA;
  logic [52:0] intA;
  logic [4:0]  classA;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fpu_input_interface dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .regA(regA), .out_valid(out_valid), .out_ready(out_ready), .modeA(modeA),
    .signA(signA), .expA(expA), .intA(intA), .classA(classA)
  );

  // Offer one operand at a falling edge; returns one falling edge after the accept edge.
  task automatic send(input logic [63:0] r, input logic m);
    regA = r; mode = m; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL reset_handshake: got out_valid/in_ready %b want 01", {out_valid, in_ready});
    end
    tests_run++;
    if ({modeA, signA, expA, intA, classA} !== 71'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h want 0", {modeA, signA, expA, intA, classA});
    end
  endtask

  task automatic test_single_one;
    send(64'h0000_0000_3F80_0000, MS);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_one_early: got out_valid %b want 0", out_valid);
    end
    @(negedge clk);
    tests_run++;
    if ({out_valid, modeA, signA, expA, intA, classA} !== {1'b1, MS, 1'b0, 11'h07F, 53'h800000, C_NORM}) begin
      tests_failed++;
      $display("FAIL single_one: got %h want %h", {out_valid, modeA, signA, expA, intA, classA},
               {1'b1, MS, 1'b0, 11'h07F, 53'h800000, C_NORM});
    end
    @(negedge clk);
  endtask

  task automatic test_double_neg2;
    send(64'hC000_0000_0000_0000, MD);
    @(negedge clk);
    tests_run++;
    if ({out_valid, modeA, signA, expA, intA, classA} !== {1'b1, MD, 1'b1, 11'h400, 53'h10000000000000, C_NORM}) begin
      tests_failed++;
      $display("FAIL double_neg2: got %h want %h", {out_valid, modeA, signA, expA, intA, classA},
               {1'b1, MD, 1'b1, 11'h400, 53'h10000000000000, C_NORM});
    end
    @(negedge clk);
  endtask

  task automatic test_specials;
    logic [63:0] vr [5];
    logic [69:0] ve [5];
    vr[0] = 64'h0000_0000_7F80_0000; ve[0] = {1'b0, 11'h0FF, 53'h800000, C_INF};
    vr[1] = 64'h0000_0000_7FC0_0000; ve[1] = {1'b0, 11'h0FF, 53'hC00000, C_NAN};
    vr[2] = 64'h0000_0000_8000_0000; ve[2] = {1'b1, 11'h000, 53'h000000, C_ZERO};
    vr[3] = 64'hFFFF_FFFF_3F80_0000; ve[3] = {1'b0, 11'h07F, 53'h800000, C_NORM};
`ifdef FPU_INPUT_INTERFACE_FTZ_EN
    vr[4] = 64'h0000_0000_0000_0001; ve[4] = {1'b0, 11'h000, 53'h000000, C_ZERO};
`else
    vr[4] = 64'h0000_0000_0000_0001; ve[4] = {1'b0, 11'h000, 53'h000001, C_SUB};
`endif
    for (int i = 0; i < 5; i++) begin
      send(vr[i], MS);
      @(negedge clk);
      tests_run++;
      if ({out_valid, signA, expA, intA, classA} !== {1'b1, ve[i]}) begin
        tests_failed++;
        $display("FAIL special_%0d: got %h want %h", i, {out_valid, signA, expA, intA, classA}, {1'b1, ve[i]});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [52:0] want [3];
    want[0] = 53'h800000; want[1] = 53'h800000; want[2] = 53'hC00000;
    regA = 64'h3F80_0000; mode = MS; in_valid = 1'b1;
    @(negedge clk);
    regA = 64'h4000_0000;
    @(negedge clk);
    regA = 64'h4040_0000;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) in_valid = 1'b0;
      tests_run++;
      if ({out_valid, intA} !== {1'b1, want[i]} || (i == 0 && in_ready !== 1'b1)) begin
        tests_failed++;
        $display("FAIL back_to_back_%0d: got v=%b rdy=%b int=%h want v=1 int=%h", i, out_valid, in_ready, intA, want[i]);
      end
      @(negedge clk);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_to_back_drain: got out_valid %b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [10:0] we [3];
    logic [52:0] wi [3];
    we[0] = 11'h07F; wi[0] = 53'h800000;
    we[1] = 11'h080; wi[1] = 53'h800000;
    we[2] = 11'h080; wi[2] = 53'hC00000;
    out_ready = 1'b0; mode = MS;
    regA = 64'h3F80_0000; in_valid = 1'b1;
    @(negedge clk);
    regA = 64'h4000_0000;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_second_accept: got in_ready %b want 1", in_ready);
    end
    @(negedge clk);
    regA = 64'h4040_0000;
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if ({in_ready, out_valid, expA, intA} !== {1'b0, 1'b1, we[0], wi[0]}) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: got rdy=%b v=%b exp=%h int=%h want rdy=0 v=1 exp=%h int=%h",
                 k, in_ready, out_valid, expA, intA, we[0], wi[0]);
      end
      if (k == 0) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      tests_run++;
      if ({out_valid, expA, intA} !== {1'b1, we[i], wi[i]}) begin
        tests_failed++;
        $display("FAIL bp_release_%0d: got v=%b exp=%h int=%h want v=1 exp=%h int=%h",
                 i, out_valid, expA, intA, we[i], wi[i]);
      end
      @(negedge clk);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain: got out_valid %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b0; mode = MS;
    regA = 64'h3F80_0000; in_valid = 1'b1;
    @(negedge clk);
    regA = 64'h4000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({out_valid, in_ready, intA, classA} !== {1'b0, 1'b1, 53'd0, 5'd0}) begin
      tests_failed++;
      $display("FAIL rst_midflight: got v=%b rdy=%b int=%h cls=%b want v=0 rdy=1 int=0 cls=0",
               out_valid, in_ready, intA, classA);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_stale_%0d: got out_valid %b want 0", i, out_valid);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = MS; regA = '0;
    @(negedge clk);
    @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_single_one;
    test_double_neg2;
    test_specials;
    test_back_to_back;
    test_backpressure;
    test_reset_midflight;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
